fib_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one Fibonacci engine among
//  NUM_REQ requesters. It accepts a request and its 4-bit index, launches the

---
 rtl/fib_arbiter_if.sv | 28 ++
 rtl/fib_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fib_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_arbiter_if.sv
// Requester and engine signals of the shared Fibonacci-engine arbiter.
// master is the arbiter side; slave is the clients plus engine side.
interface fib_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_n;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [9:0]           rsp_result;
    logic                 rsp_error;
    logic                 busy;
    logic                 eng_start;
    logic [3:0]           eng_n;
    logic [9:0]           eng_result;
    logic                 eng_done;
    logic                 eng_clear;

    modport master (
        input  req, req_n, eng_result, eng_done,
        output gnt, rsp_valid, rsp_result, rsp_error, busy, eng_start, eng_n, eng_clear
    );

    modport slave (
        output req, req_n, eng_result, eng_done,
        input  gnt, rsp_valid, rsp_result, rsp_error, busy, eng_start, eng_n, eng_clear
    );
endinterface

// File: rtl/fib_arbiter.sv
// Round-robin arbiter that serialises jobs from NUM_REQ clients onto one
// Fibonacci engine, with a watchdog that aborts a stuck engine.
module fib_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    fib_arbiter_if.master bus_io
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDeliver} state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]      job_w_q, job_w_d;
    logic [WdW-1:0]       wdog_q, wdog_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [9:0]           rsp_result_q, rsp_result_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 busy_q, busy_d;
    logic                 eng_start_q, eng_start_d;
    logic                 eng_clear_q, eng_clear_d;
    logic [3:0]           eng_n_q, eng_n_d;

    logic [3:0]           req_n_arr [NUM_REQ];
    logic                 any_req;
    logic [PtrW-1:0]      win;
    logic [NUM_REQ-1:0]   job_onehot;
    logic [PtrW-1:0]      job_next;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_n_arr[i] = bus_io.req_n[4*i +: 4];
        end
    end

    // First set request scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] idx_w;
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PtrW'(idx);
            if (!any_req && bus_io.req[idx_w]) begin
                any_req = 1'b1;
                win     = idx_w;
            end
        end
    end

    assign job_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << job_w_q;
    assign job_next   = (job_w_q == PtrW'(NUM_REQ - 1)) ? '0 : job_w_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        job_w_d      = job_w_q;
        wdog_d       = wdog_q;
        eng_n_d      = eng_n_q;
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_result_d = '0;
        rsp_error_d  = 1'b0;
        eng_start_d  = 1'b0;
        eng_clear_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Outputs are registered, so pulses that belong to LAUNCH are set here.
                if (any_req) begin
                    state_d     = StLaunch;
                    job_w_d     = win;
                    eng_n_d     = req_n_arr[win];
                    gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    eng_start_d = 1'b1;
                end
            end
            StLaunch: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done in the final watchdog cycle still counts as success.
                if (bus_io.eng_done) begin
                    state_d      = StDeliver;
                    rsp_valid_d  = job_onehot;
                    rsp_result_d = bus_io.eng_result;
                end else if (wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StDeliver;
                    rsp_valid_d = job_onehot;
                    rsp_error_d = 1'b1;
                    eng_clear_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StDeliver: begin
                rr_ptr_d = job_next;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            job_w_q      <= '0;
            wdog_q       <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_clear_q  <= 1'b0;
            eng_n_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            job_w_q      <= job_w_d;
            wdog_q       <= wdog_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            busy_q       <= busy_d;
            eng_start_q  <= eng_start_d;
            eng_clear_q  <= eng_clear_d;
            eng_n_q      <= eng_n_d;
        end
    end

    assign bus_io.gnt        = gnt_q;
    assign bus_io.rsp_valid  = rsp_valid_q;
    assign bus_io.rsp_result = rsp_result_q;
    assign bus_io.rsp_error  = rsp_error_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.eng_start  = eng_start_q;
    assign bus_io.eng_n      = eng_n_q;
    assign bus_io.eng_clear  = eng_clear_q;

`ifndef SYNTHESIS
    gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    rsp_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid_q));
`endif
endmodule

// File: tb/tb_fib_arbiter.sv
// Directed bench for fib_arbiter: table of single jobs plus hand-written
// fairness and reset-mid-job sequences against a simple engine model.
module tb_fib_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 64;

    typedef struct {
        logic [3:0] req;
        logic [3:0] n;
        int         lat;
        bit         en;
        logic [3:0] exp_gnt;
        logic [9:0] exp_res;
        bit         exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    int         cyc, n_starts, n_clears, n_rsps, start_cyc, rsp_cyc;
    logic [3:0] start_n;
    logic [3:0] gnt_log [$];
    bit         eng_en;
    int         eng_lat;

    vec_t vecs [9];

    fib_arbiter_if #(.NUM_REQ(NR)) bus ();

    fib_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] fib(input logic [3:0] n);
        logic [9:0] a = 10'd0;
        logic [9:0] b = 10'd1;
        logic [9:0] t;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Engine model: done pulse eng_lat cycles after it sees eng_start.
    initial begin
        logic [3:0] n;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        forever begin
            @(negedge clk);
            if (bus.eng_start && eng_en) begin
                n = bus.eng_n;
                repeat (eng_lat) @(negedge clk);
                bus.eng_done   = 1'b1;
                bus.eng_result = fib(n);
                @(negedge clk);
                bus.eng_done   = 1'b0;
                bus.eng_result = '0;
            end
        end
    end

    initial begin
        cyc = 0; n_starts = 0; n_clears = 0; n_rsps = 0; start_cyc = 0; rsp_cyc = 0;
        start_n = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.eng_start) begin
                n_starts++;
                start_n   = bus.eng_n;
                start_cyc = cyc;
            end
            if (bus.eng_clear) n_clears++;
            if (bus.gnt != '0) gnt_log.push_back(bus.gnt);
            if (bus.rsp_valid != '0) begin
                n_rsps++;
                rsp_cyc = cyc;
            end else if (bus.rsp_result != '0) begin
                check("rsp_result_idle", bus.rsp_result, 0);
            end
            if (!$onehot0(bus.gnt)) check("gnt_onehot", bus.gnt, 0);
            if (!$onehot0(bus.rsp_valid)) check("rsp_onehot", bus.rsp_valid, 0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},        bus.gnt,        0);
        check({tag, "_rsp_valid"},  bus.rsp_valid,  0);
        check({tag, "_rsp_result"}, bus.rsp_result, 0);
        check({tag, "_rsp_error"},  bus.rsp_error,  0);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_eng_start"},  bus.eng_start,  0);
        check({tag, "_eng_n"},      bus.eng_n,      0);
        check({tag, "_eng_clear"},  bus.eng_clear,  0);
    endtask

    task automatic do_job(input vec_t v, input string tag);
        int w;
        n_starts = 0; n_clears = 0; n_rsps = 0; start_n = '0;
        eng_en      = v.en;
        eng_lat     = v.lat;
        bus.req     = v.req;
        bus.req_n   = {4{v.n}};
        w = 0;
        do begin
            step();
            w++;
        end while (bus.gnt == '0 && w < 10);
        check({tag, "_gnt"}, bus.gnt, v.exp_gnt);
        check({tag, "_busy"}, bus.busy, 1);
        bus.req = '0;
        w = 0;
        while (bus.rsp_valid == '0 && w < 200) begin
            step();
            w++;
        end
        check({tag, "_rsp_valid"},  bus.rsp_valid,  v.exp_gnt);
        check({tag, "_rsp_result"}, bus.rsp_result, v.exp_res);
        check({tag, "_rsp_error"},  bus.rsp_error,  v.exp_err);
        step();
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_starts"},    n_starts, 1);
        check({tag, "_eng_n"},     start_n,  v.n);
        check({tag, "_clears"},    n_clears, v.exp_err);
        check({tag, "_latency"},   rsp_cyc - start_cyc, v.en ? v.lat + 1 : TO + 1);
        repeat (3) step();
        check({tag, "_rsps"}, n_rsps, 1);
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int         w;
        logic [3:0] ord [4];
        logic [9:0] fres [4];
        vec_t       v;

        tests = 0; fails = 0;
        reset = 1'b1; bus.req = '0; bus.req_n = '0; eng_en = 1'b0; eng_lat = 1;
        repeat (2) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check("post_reset_busy", bus.busy, 0);

        //            req      n      lat en  gnt      res      err
        vecs[0] = '{4'b0010, 4'd10, 3,  1, 4'b0010, 10'd55,  0};
        vecs[1] = '{4'b0001, 4'd0,  2,  1, 4'b0001, 10'd0,   0};
        vecs[2] = '{4'b0100, 4'd1,  1,  1, 4'b0100, 10'd1,   0};
        vecs[3] = '{4'b1000, 4'd15, 5,  1, 4'b1000, 10'd610, 0};
        vecs[4] = '{4'b1111, 4'd7,  4,  1, 4'b0001, 10'd13,  0};  // rr_ptr wrapped to 0
        vecs[5] = '{4'b0110, 4'd11, 2,  1, 4'b0010, 10'd89,  0};  // rr_ptr 1
        vecs[6] = '{4'b1000, 4'd5,  1,  0, 4'b1000, 10'd0,   1};  // engine silent
        vecs[7] = '{4'b0101, 4'd9,  64, 1, 4'b0001, 10'd34,  0};  // done in timeout cycle
        vecs[8] = '{4'b0100, 4'd13, 63, 1, 4'b0100, 10'd233, 0};
        for (int i = 0; i < 9; i++) begin
            do_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Fairness: all four held, each dropped once served.
        apply_reset();
        gnt_log.delete();
        eng_en    = 1'b1;
        eng_lat   = 2;
        bus.req_n = {4'd9, 4'd8, 4'd7, 4'd6};
        bus.req   = 4'b1111;
        ord  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        fres = '{10'd8, 10'd13, 10'd21, 10'd34};
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (bus.rsp_valid == '0 && w < 100) begin
                step();
                w++;
            end
            check($sformatf("fair_rsp%0d", k), bus.rsp_valid, ord[k]);
            check($sformatf("fair_res%0d", k), bus.rsp_result, fres[k]);
            bus.req = bus.req & ~bus.rsp_valid;
            step();
        end
        check("fair_gnt_count", gnt_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gnt_log.size()) check($sformatf("fair_gnt%0d", k), gnt_log[k], ord[k]);
        end

        bus.req = 4'b0101;
        ord[0] = 4'b0001; ord[1] = 4'b0100;
        fres[0] = 10'd8;  fres[1] = 10'd21;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (bus.rsp_valid == '0 && w < 100) begin
                step();
                w++;
            end
            check($sformatf("rr2_rsp%0d", k), bus.rsp_valid, ord[k]);
            check($sformatf("rr2_res%0d", k), bus.rsp_result, fres[k]);
            bus.req = bus.req & ~bus.rsp_valid;
            step();
        end

        // Reset while waiting on the engine drops the job silently.
        eng_en    = 1'b0;
        bus.req   = 4'b1000;
        bus.req_n = {4{4'd12}};
        w = 0;
        do begin
            step();
            w++;
        end while (bus.gnt == '0 && w < 10);
        check("midrst_gnt", bus.gnt, 4'b1000);
        bus.req = '0;
        repeat (5) step();
        check("midrst_busy_before", bus.busy, 1);
        n_rsps = 0; n_starts = 0;
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        step();
        step();
        reset = 1'b0;
        repeat (80) step();
        check("midrst_no_rsp",   n_rsps,   0);
        check("midrst_no_start", n_starts, 0);
        check("midrst_idle",     bus.busy, 0);
        v = '{4'b0001, 4'd12, 3, 1, 4'b0001, 10'd144, 0};
        do_job(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "timeout");
    end
endmodule
